// File: rtl/uart_rx_sample_timer.sv
// rtl/uart_rx_sample_timer.sv - UART receive bit-timing engine: start detect, oversample counting, voted sample strobes
module uart_rx_sample_timer #(
  parameter int OVERSAMPLE   = 16,
  parameter int SAMPLE_POINT = OVERSAMPLE / 2,
  parameter int MAJORITY     = 1,
  parameter int FRAME_BITS   = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          tick_i,
  input  logic                          rxd_i,
  output logic                          sample_o,
  output logic                          bit_o,
  output logic [$clog2(FRAME_BITS)-1:0] bit_idx_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          start_err_o,
  output logic                          stop_err_o
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(FRAME_BITS);

  localparam logic [OSW-1:0] OS_ONE   = OSW'(1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] V0_PT    = OSW'(SAMPLE_POINT - 1);
  localparam logic [OSW-1:0] V1_PT    = OSW'(SAMPLE_POINT);
  localparam logic [OSW-1:0] DEC_PT   = OSW'(SAMPLE_POINT + MAJORITY);
  localparam logic [BW-1:0]  BIT_ONE  = BW'(1);
  localparam logic [BW-1:0]  STOP_IDX = BW'(FRAME_BITS - 1);
  localparam bit             USE_VOTE = (MAJORITY != 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [OSW-1:0] os_q, os_d, os_adv;
  logic [BW-1:0]  bit_q, bit_d, bit_adv;
  logic [1:0]     vote_q, vote_d;
  logic [BW-1:0]  idx_d;
  logic           sample_d, bitv_d, done_d, serr_d, perr_d, result;

  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    bit_d    = bit_q;
    vote_d   = vote_q;
    sample_d = 1'b0;
    bitv_d   = bit_o;
    idx_d    = bit_idx_o;
    done_d   = 1'b0;
    serr_d   = 1'b0;
    perr_d   = 1'b0;

    // os_adv/bit_adv name the position of the tick arriving now
    os_adv  = (os_q == OS_LAST) ? '0 : os_q + OS_ONE;
    bit_adv = (os_q == OS_LAST) ? bit_q + BIT_ONE : bit_q;

    if (USE_VOTE)
      result = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_i) | (vote_q[1] & rxd_i);
    else
      result = rxd_i;

    case (state_q)
      IDLE: begin
        if (tick_i && !rxd_i) begin
          state_d = RUN;
          os_d    = '0;
          bit_d   = '0;
          vote_d  = '0;
        end
      end
      RUN: begin
        if (tick_i) begin
          os_d  = os_adv;
          bit_d = bit_adv;
          if (os_adv == V0_PT) vote_d[0] = rxd_i;
          if (os_adv == V1_PT) vote_d[1] = rxd_i;
          if (os_adv == DEC_PT) begin
            sample_d = 1'b1;
            bitv_d   = result;
            idx_d    = bit_adv;
            if (bit_adv == '0 && result) begin
              serr_d  = 1'b1;
              state_d = IDLE;
            end else if (bit_adv == STOP_IDX) begin
              // leave at the stop-bit decision so the next start edge is seen on the next tick
              done_d  = 1'b1;
              perr_d  = ~result;
              state_d = IDLE;
            end
            if (state_d == IDLE) begin
              os_d  = '0;
              bit_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      state_q      <= IDLE;
      os_q         <= '0;
      bit_q        <= '0;
      vote_q       <= '0;
      sample_o     <= 1'b0;
      bit_o        <= 1'b0;
      bit_idx_o    <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      start_err_o  <= 1'b0;
      stop_err_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      os_q         <= os_d;
      bit_q        <= bit_d;
      vote_q       <= vote_d;
      sample_o     <= sample_d;
      bit_o        <= bitv_d;
      bit_idx_o    <= idx_d;
      busy_o       <= (state_d == RUN);
      frame_done_o <= done_d;
      start_err_o  <= serr_d;
      stop_err_o   <= perr_d;
    end
  end

endmodule

// File: doc/uart_rx_sample_timer.md
# uart_rx_sample_timer

Parametrised receive-side bit-timing engine for the UART receiver. It sits between the baud-tick generator and the receive shift register. It detects a start edge on the synchronised serial line and counts oversampling ticks. At the programmable sample point of every bit in the frame it produces a (optionally majority-voted) sample strobe. It also flags false starts and framing (stop-bit) errors.

## Interface
- OVERSAMPLE, 16: ticks per bit period; legal range 4..64.
- SAMPLE_POINT, OVERSAMPLE/2: tick index (0-based, within a bit) of the centre sample; legal range 1..OVERSAMPLE-2.
- MAJORITY, 1: 1 = 2-of-3 vote over ticks SAMPLE_POINT-1, SAMPLE_POINT, SAMPLE_POINT+1; 0 = single sample at SAMPLE_POINT.
- FRAME_BITS, 10: total bits per frame including start and stop; legal range 3..16.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  receiver enable; low acts as synchronous clear.
- tick_i  in  1  single-cycle oversampling strobe, OVERSAMPLE per bit; may be asserted on consecutive cycles.
- rxd_i  in  1  serial line, already synchronised to clk_i; idle high.
- sample_o  out  1  one-cycle pulse: bit_o/bit_idx_o valid.
- bit_o  out  1  sampled or voted bit value; holds until next sample_o.
- bit_idx_o  out  $clog2(FRAME_BITS)  index of the bit just sampled (0 = start); holds until next sample_o.
- busy_o  out  1  high while a frame is in progress.
- frame_done_o  out  1  one-cycle pulse with the stop-bit sample_o.
- start_err_o  out  1  one-cycle pulse: start bit sampled high (false start).
- stop_err_o  out  1  one-cycle pulse with frame_done_o when the stop bit sampled low.

## Operation
- Reset values: every output 0; state IDLE; os_cnt = 0; bit_cnt = 0; vote register cleared.
- rst_i or en_i=0 forces the reset state in the same edge. A frame in progress is abandoned without frame_done_o or any error pulse. rst_i/en_i low has priority over every other event.
- **IDLE:**
  - A tick with rxd_i = 0 enters RUN with os_cnt = 0 and bit_cnt = 0. That tick is tick 0 of the start bit.
  - busy_o rises on the next clock edge.
  - Ticks with rxd_i = 1 do nothing.
- **RUN, per tick:**
  - os_cnt increments. At OVERSAMPLE-1 it wraps to 0 and bit_cnt increments.
  - With MAJORITY=1, rxd_i is captured at ticks SAMPLE_POINT-1, SAMPLE_POINT and SAMPLE_POINT+1. The vote (2 of 3) is evaluated at the SAMPLE_POINT+1 tick.
  - With MAJORITY=0, rxd_i is taken directly at the SAMPLE_POINT tick.
- **Decision tick:** the tick where the vote or sample is taken.
  - sample_o pulses. bit_o = result; bit_idx_o = bit_cnt.
  - bit_cnt = 0 with result 1: start_err_o pulses together with sample_o, and the state returns to IDLE.
  - bit_cnt = FRAME_BITS-1 (stop bit): frame_done_o pulses, and stop_err_o = ~result. The state returns to IDLE immediately, without waiting for the end of the stop-bit period, so a following start edge can be caught on the very next tick.
  - Other bits: remain in RUN.
- Line activity other than at the sample ticks is ignored; there is no mid-bit resynchronisation.
- Counter widths: os_cnt is $clog2(OVERSAMPLE) bits and bit_cnt is $clog2(FRAME_BITS) bits. Neither overflows, because RUN always exits at or before bit_cnt = FRAME_BITS-1.

## Timing
- All outputs are registered. sample_o and companions go high in the clock cycle after the decision tick, and are high for exactly one cycle.
- busy_o goes high the cycle after the start-detect tick. It goes low in the same cycle that frame_done_o or start_err_o is high.
- Latency from the start-detect tick to the first sample_o is SAMPLE_POINT+MAJORITY ticks plus 1 clock. Successive sample_o pulses are exactly OVERSAMPLE ticks apart.
- Back-to-back frames: a start-detect tick is accepted on the first tick after the stop-bit decision tick.
- tick_i asserted in the same cycle as en_i falling: the tick is ignored.

## Test plan
- **Clean frame:** defaults, tick every 4 clocks, frame 0 / 0x5A LSB-first / 1.
  - Exactly 10 sample_o pulses, bit_idx_o 0..9, bit_o 0,0,1,0,1,1,0,1,0,1.
  - frame_done_o=1 and stop_err_o=0 with the 10th pulse.
  - First pulse arrives 9 ticks + 1 clock after the start-detect tick.
- **False start:** rxd_i low for 5 ticks, then high.
  - start_err_o and sample_o pulse at tick 9 with bit_o=1.
  - busy_o drops; no further samples.
- **Majority filter:** single-tick glitch (rxd_i=1 at tick 8 only) in data bit 3 = 0.
  - bit_o=0 at bit_idx_o=3 with MAJORITY=1.
  - Rerun with MAJORITY=0: bit_o=1.
- **Framing error:** stop bit driven 0.
  - frame_done_o=1 and stop_err_o=1 on bit_idx_o=9.
  - A new start on the next tick is accepted and produces a full frame.
- **Mid-frame abort:** en_i=0 during bit 4, later re-enabled.
  - No further sample_o, frame_done_o or errors; busy_o=0 the next cycle.
  - After re-enable, the next frame decodes correctly.
  - Repeat with rst_i: same result.
- **Parameter sweep:** OVERSAMPLE=8, SAMPLE_POINT=4, FRAME_BITS=11, ticks every cycle.
  - sample_o spacing is exactly 8 ticks, with 11 pulses per frame.
  - frame_done_o arrives on bit_idx_o=10.
